// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus constants and the OAM DMA sequencer state encoding.
package nes_bus_pkg;

  localparam logic [15:0] NES_ADDR_OAMDMA = 16'h4014;
  localparam int          NES_OAM_LEN     = 256;
  localparam int          DMA_STATE_W     = 3;

  typedef enum logic [DMA_STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/oam_dma_ctrl_cpu_bus_mux.sv
// RAM-port steering: CPU passthrough when idle, DMA drive otherwise, select
// forced inactive while blocked (reset or DMA-register write).
module cpu_bus_mux (
  input  logic        i_sel_dma,
  input  logic        i_block,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_rw_n,
  input  logic        i_cpu_cs_n,
  input  logic [15:0] i_dma_addr,
  input  logic        i_dma_rw_n,
  input  logic        i_dma_cs_n,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rw_n,
  output logic        o_mem_cs_n
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    o_mem_rw_n  = i_cpu_rw_n;
    o_mem_cs_n  = i_cpu_cs_n;
    if (i_sel_dma) begin
      o_mem_addr  = i_dma_addr;
      o_mem_wdata = 8'h00;
      o_mem_rw_n  = i_dma_rw_n;
      o_mem_cs_n  = i_dma_cs_n;
    end
    if (i_block) begin
      o_mem_cs_n = 1'b1;
    end
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA sequencer on the CPU RAM bus. Optional macro
// OAM_DMA_PARITY_ALIGN_EN adds a parity-driven ALIGN cycle after HALT.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = NES_ADDR_OAMDMA,
  parameter int          XFER_LEN     = NES_OAM_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw_n,
  input  logic        cpu_cs_n,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rw_n,
  output logic        mem_cs_n,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_busy
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_e r_state;
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic       r_cpu_rdy;
  logic       r_dma_busy;
  logic       r_oam_we;
  logic [7:0] r_oam_addr;

  logic w_trigger;
  logic w_need_align;

  assign w_trigger = (r_state == ST_IDLE) && !cpu_cs_n && !cpu_rw_n &&
                     (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_PARITY_ALIGN_EN
  logic r_parity;

  always_ff @(posedge clk) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ~r_parity;
  end

  assign w_need_align = r_parity;
`else
  assign w_need_align = 1'b0;
`endif

  // cpu_rdy/dma_busy are set on the edge that enters or leaves IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= 8'h00;
      r_page     <= 8'h00;
      r_cpu_rdy  <= 1'b1;
      r_dma_busy <= 1'b0;
      r_oam_we   <= 1'b0;
      r_oam_addr <= 8'h00;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      r_oam_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_page     <= cpu_wdata;
            r_idx      <= 8'h00;
            r_state    <= ST_HALT;
            r_cpu_rdy  <= 1'b0;
            r_dma_busy <= 1'b1;
          end
        end
        ST_HALT:  r_state <= w_need_align ? ST_ALIGN : ST_READ;
        ST_ALIGN: r_state <= ST_READ;
        ST_READ: begin
          r_state    <= ST_WRITE;
          r_oam_we   <= 1'b1;
          r_oam_addr <= r_idx;
        end
        ST_WRITE: begin
          if (r_idx == LAST_IDX) begin
            r_idx      <= 8'h00;
            r_state    <= ST_IDLE;
            r_cpu_rdy  <= 1'b1;
            r_dma_busy <= 1'b0;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= ST_READ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  cpu_bus_mux u_bus_mux (
    .i_sel_dma   (r_state != ST_IDLE),
    .i_block     (rst || w_trigger),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .i_cpu_rw_n  (cpu_rw_n),
    .i_cpu_cs_n  (cpu_cs_n),
    .i_dma_addr  ({r_page, r_idx}),
    .i_dma_rw_n  (1'b1),
    .i_dma_cs_n  (r_state != ST_READ),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_rw_n  (mem_rw_n),
    .o_mem_cs_n  (mem_cs_n)
  );

  // RAM data arrives during WRITE, so it goes to OAM unregistered.
  assign oam_wdata = r_oam_we ? mem_rdata : 8'h00;
  assign oam_we    = r_oam_we;
  assign oam_addr  = r_oam_addr;
  assign cpu_rdata = mem_rdata;
  assign cpu_rdy   = r_cpu_rdy;
  assign dma_busy  = r_dma_busy;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: behavioural RAM/OAM, cycle-index DMA
// model checked every cycle, plus directed literal checks and random traffic.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_PARITY_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw_n;
  logic        cpu_cs_n;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rw_n;
  logic        mem_cs_n;
  logic [7:0]  mem_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_busy;

  oam_dma_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rw_n  (cpu_rw_n),
    .cpu_cs_n  (cpu_cs_n),
    .cpu_rdata (cpu_rdata),
    .cpu_rdy   (cpu_rdy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw_n  (mem_rw_n),
    .mem_cs_n  (mem_cs_n),
    .mem_rdata (mem_rdata),
    .oam_addr  (oam_addr),
    .oam_wdata (oam_wdata),
    .oam_we    (oam_we),
    .dma_busy  (dma_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural RAM and OAM; bus sampled mid-cycle, acted on at the edge.
  logic [7:0]  ram [65536];
  logic [7:0]  oam [256];
  logic        q_cs_n = 1'b1;
  logic        q_rw_n = 1'b1;
  logic [15:0] q_addr = 16'h0000;
  logic [7:0]  q_wdata = 8'h00;

  initial mem_rdata = 8'h00;

  always @(negedge clk) begin
    q_cs_n  = mem_cs_n;
    q_rw_n  = mem_rw_n;
    q_addr  = mem_addr;
    q_wdata = mem_wdata;
    if (oam_we === 1'b1) oam[oam_addr] = oam_wdata;
  end

  always @(posedge clk) begin
    if (q_cs_n === 1'b0) begin
      if (!q_rw_n) ram[q_addr] = q_wdata;
      else         mem_rdata   = ram[q_addr];
    end
  end

  // Model: which cycle of a DMA we are in, counted from the trigger edge.
  bit         m_valid  = 1'b0;
  bit         m_active = 1'b0;
  bit         m_par    = 1'b0;
  bit         m_align  = 1'b0;
  int         m_n      = 0;
  logic [7:0] m_page   = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      m_par    = 1'b0;
      m_align  = 1'b0;
    end else if (m_valid) begin
      if (m_active) begin
        if (m_n == 1) m_align = ALIGN_EN && m_par;
        if (m_n == 1 + int'(m_align) + 512) m_active = 1'b0;
        else m_n++;
      end else if (!cpu_cs_n && !cpu_rw_n && cpu_addr == 16'h4014) begin
        m_active = 1'b1;
        m_n      = 1;
        m_page   = cpu_wdata;
      end
      m_par = !m_par;
    end
  end

  int         c_j;
  logic [7:0] c_idx;
  logic       c_trig;

  always @(negedge clk) begin
    if (m_valid) begin
      check("cpu_rdata", cpu_rdata, mem_rdata);
      if (rst) check("rst_mem_cs_n", mem_cs_n, 1'b1);
      if (m_active) begin
        check("cpu_rdy_dma", cpu_rdy, 1'b0);
        check("dma_busy_dma", dma_busy, 1'b1);
        c_j   = m_n - 2 - int'(m_align);
        c_idx = 8'(c_j / 2);
        if (c_j >= 0 && (c_j % 2) == 0) begin
          check("rd_oam_we", oam_we, 1'b0);
          if (!rst) begin
            check("rd_mem_cs_n", mem_cs_n, 1'b0);
            check("rd_mem_rw_n", mem_rw_n, 1'b1);
            check("rd_mem_addr", mem_addr, {m_page, c_idx});
          end
        end else if (c_j >= 0) begin
          check("wr_oam_we", oam_we, 1'b1);
          check("wr_oam_addr", oam_addr, c_idx);
          check("wr_oam_wdata", oam_wdata, ram[{m_page, c_idx}]);
          check("wr_mem_cs_n", mem_cs_n, 1'b1);
        end else begin
          check("halt_oam_we", oam_we, 1'b0);
          check("halt_mem_cs_n", mem_cs_n, 1'b1);
        end
      end else begin
        check("cpu_rdy_idle", cpu_rdy, 1'b1);
        check("dma_busy_idle", dma_busy, 1'b0);
        check("oam_we_idle", oam_we, 1'b0);
        if (!rst) begin
          c_trig = !cpu_cs_n && !cpu_rw_n && cpu_addr == 16'h4014;
          check("pass_mem_addr", mem_addr, cpu_addr);
          check("pass_mem_wdata", mem_wdata, cpu_wdata);
          check("pass_mem_rw_n", mem_rw_n, cpu_rw_n);
          check("pass_mem_cs_n", mem_cs_n, c_trig ? 1'b1 : cpu_cs_n);
        end
      end
    end
  end

  // Stimulus helpers: every task starts and ends 2 time units after a posedge.
  task automatic idle_cycle();
    cpu_cs_n = 1'b1;
    cpu_rw_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_rw_n = 1'b0; cpu_cs_n = 1'b0;
    @(posedge clk); #2;
    cpu_cs_n = 1'b1; cpu_rw_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    cpu_addr = a; cpu_rw_n = 1'b1; cpu_cs_n = 1'b0;
    @(posedge clk); #1;
    d = cpu_rdata;
    #1;
    cpu_cs_n = 1'b1;
  endtask

  // Make the HALT cycle of a trigger issued now see parity p.
  task automatic align_to(input bit p);
    if (m_par == p) idle_cycle();
  endtask

  task automatic start_dma(input logic [7:0] page, input bit hold_read,
                           output int lows, output int pulses,
                           output logic [15:0] first_rd, output logic [15:0] last_rd,
                           output int zero_hits);
    bit got;
    got = 1'b0;
    lows = 0; pulses = 0; zero_hits = 0; first_rd = 16'h0; last_rd = 16'h0;
    cpu_addr = 16'h4014; cpu_wdata = page; cpu_rw_n = 1'b0; cpu_cs_n = 1'b0;
    @(negedge clk);
    check("trig_mem_cs_n", mem_cs_n, 1'b1);
    @(posedge clk); #2;
    if (hold_read) begin
      cpu_addr = 16'($urandom); cpu_rw_n = 1'b1; cpu_cs_n = 1'b0;
    end else begin
      cpu_cs_n = 1'b1; cpu_rw_n = 1'b1;
    end
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (cpu_rdy === 1'b1) break;
      lows++;
      if (mem_cs_n === 1'b0) begin
        if (!got) first_rd = mem_addr;
        got     = 1'b1;
        last_rd = mem_addr;
        if (mem_addr == 16'h0000) zero_hits++;
      end
      if (oam_we === 1'b1) pulses++;
    end
    check("dma_timeout", (lows >= 1000), 1'b0);
    @(posedge clk); #2;
    cpu_cs_n = 1'b1; cpu_rw_n = 1'b1;
  endtask

  task automatic verify_oam(input logic [7:0] page);
    for (int i = 0; i < 256; i++) check("oam_vs_ram", oam[i], ram[{page, 8'(i)}]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lows, pulses, zhits;
    logic [15:0] f_rd, l_rd;
    logic [7:0]  rd, pg;

    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      ram[16'h0200 + 16'(i)] = 8'(i) ^ 8'h5A;
      oam[i] = 8'h00;
    end

    // Reset with a DMA-register write held on the bus: no access, no DMA.
    rst = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h77; cpu_rw_n = 1'b0; cpu_cs_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_cs_n", mem_cs_n, 1'b1);
    check("reset_cpu_rdy", cpu_rdy, 1'b1);
    check("reset_dma_busy", dma_busy, 1'b0);
    check("reset_oam_we", oam_we, 1'b0);
    check("reset_oam_addr", oam_addr, 8'h00);
    check("reset_oam_wdata", oam_wdata, 8'h00);
    @(posedge clk); #2;
    rst = 1'b0; cpu_cs_n = 1'b1; cpu_rw_n = 1'b1;
    idle_cycle();

    // Idle passthrough write then read-back.
    cpu_addr = 16'h0010; cpu_wdata = 8'hA5; cpu_rw_n = 1'b0; cpu_cs_n = 1'b0;
    @(negedge clk);
    check("t1_mem_addr", mem_addr, 16'h0010);
    check("t1_mem_wdata", mem_wdata, 8'hA5);
    check("t1_mem_rw_n", mem_rw_n, 1'b0);
    check("t1_mem_cs_n", mem_cs_n, 1'b0);
    @(posedge clk); #2;
    cpu_read(16'h0010, rd);
    check("t1_cpu_rdata", rd, 8'hA5);
    check("t1_cpu_rdy", cpu_rdy, 1'b1);

    // DMA page 02 with a known pattern.
    align_to(1'b0);
    start_dma(8'h02, 1'b0, lows, pulses, f_rd, l_rd, zhits);
    check("t2_pulses", pulses, 256);
    check("t2_lows", lows, 513);
    for (int i = 0; i < 256; i++) check("t2_oam", oam[i], 8'(i) ^ 8'h5A);

    // Stall length with each HALT parity.
    align_to(1'b0);
    start_dma(8'h11, 1'b1, lows, pulses, f_rd, l_rd, zhits);
    check("t3_lows_par0", lows, 513);
    align_to(1'b1);
    start_dma(8'h12, 1'b0, lows, pulses, f_rd, l_rd, zhits);
    check("t3_lows_par1", lows, ALIGN_EN ? 514 : 513);
    verify_oam(8'h12);

    // Last page: no wrap into page 00, and the next DMA starts at index 0.
    start_dma(8'hFF, 1'b0, lows, pulses, f_rd, l_rd, zhits);
    check("t4_first_rd", f_rd, 16'hFF00);
    check("t4_last_rd", l_rd, 16'hFFFF);
    check("t4_zero_hits", zhits, 0);
    verify_oam(8'hFF);
    start_dma(8'h21, 1'b0, lows, pulses, f_rd, l_rd, zhits);
    check("t4_next_first_rd", f_rd, 16'h2100);

    // Reset while writing index 0x40.
    cpu_addr = 16'h4014; cpu_wdata = 8'h05; cpu_rw_n = 1'b0; cpu_cs_n = 1'b0;
    @(posedge clk); #2;
    cpu_cs_n = 1'b1; cpu_rw_n = 1'b1;
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (oam_we === 1'b1 && oam_addr == 8'h40) begin
          hit = 1'b1;
          break;
        end
      end
      check("t5_reached_idx40", hit, 1'b1);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("t5_cpu_rdy", cpu_rdy, 1'b1);
    check("t5_dma_busy", dma_busy, 1'b0);
    check("t5_oam_we", oam_we, 1'b0);
    check("t5_mem_cs_n", mem_cs_n, 1'b1);
    check("t5_partial_oam", oam[8'h40], ram[16'h0540]);
    #1 rst = 1'b0;
    idle_cycle();
    start_dma(8'h03, 1'b0, lows, pulses, f_rd, l_rd, zhits);
    check("t5_pulses", pulses, 256);
    check("t5_first_rd", f_rd, 16'h0300);
    verify_oam(8'h03);

    // CPU read of the DMA register passes through.
    cpu_addr = 16'h4014; cpu_rw_n = 1'b1; cpu_cs_n = 1'b0;
    @(negedge clk);
    check("t6_mem_cs_n", mem_cs_n, 1'b0);
    check("t6_mem_rw_n", mem_rw_n, 1'b1);
    check("t6_mem_addr", mem_addr, 16'h4014);
    @(posedge clk); #2;
    cpu_cs_n = 1'b1;
    @(negedge clk);
    check("t6_no_dma", dma_busy, 1'b0);
    @(posedge clk); #2;

    // Random CPU traffic interleaved with random-page DMAs.
    for (int it = 0; it < 5; it++) begin
      int n_ops;
      n_ops = int'($urandom_range(8, 1));
      for (int k = 0; k < n_ops; k++) begin
        logic [15:0] a;
        logic [7:0]  exp_d;
        a = 16'($urandom);
        if (a == 16'h4014) a = 16'h4015;
        if ($urandom_range(1, 0) == 1) begin
          cpu_write(a, 8'($urandom));
        end else begin
          exp_d = ram[a];
          cpu_read(a, rd);
          check("rnd_cpu_read", rd, exp_d);
        end
        if ($urandom_range(1, 0) == 1) idle_cycle();
      end
      pg = 8'($urandom);
      start_dma(pg, 1'($urandom_range(1, 0)), lows, pulses, f_rd, l_rd, zhits);
      check("rnd_pulses", pulses, 256);
      check("rnd_last_rd", l_rd, {pg, 8'hFF});
      verify_oam(pg);
    end

    repeat (2) idle_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
